// File: rtl/button_event_pkg.sv
// Shared types and helpers for the pushbutton event generator.
// Holds the sequence state encoding and the ms-to-cycles conversion.
package button_event_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DOWN1,
    LONG,
    WAIT2,
    DOWN2
  } state_t;

  // 64-bit product so long holds at fast clocks do not overflow
  function automatic int unsigned ms_to_cycles(
    input int unsigned ms,
    input int unsigned clkfreq
  );
    logic [63:0] prod;
    prod = (64'(ms) * 64'(clkfreq)) / 64'd1000;
    return prod[31:0];
  endfunction

endpackage

// File: rtl/pb_edge_det.sv
// Registers the debounced button level and flags rising/falling edges.
// Edges are combinational against the one-cycle-old level.
module pb_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 1'b0;
    end else begin
      r_q <= d;
    end
  end

  assign q    = r_q;
  assign rise = d & ~r_q;
  assign fall = ~d & r_q;

endmodule

// File: rtl/button_event.sv
// Turns a debounced button level into press/release/click/dclick,
// long-press and auto-repeat pulses, all registered one cycle late.
module button_event
  import button_event_pkg::*;
#(
  parameter int unsigned CLKPD_NS  = 10,
  parameter int unsigned CLKFREQ   = 1_000_000_000 / CLKPD_NS,
  parameter int unsigned LONG_MS   = 500,
  parameter int unsigned REPEAT_MS = 100,
  parameter int unsigned DCLICK_MS = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_debounced,
  output logic press,
  output logic release_p,
  output logic click,
  output logic dclick,
  output logic long_press,
  output logic repeat_p,
  output logic held
);

  localparam int unsigned L = ms_to_cycles(LONG_MS, CLKFREQ);
  localparam int unsigned R = ms_to_cycles(REPEAT_MS, CLKFREQ);
  localparam int unsigned D = ms_to_cycles(DCLICK_MS, CLKFREQ);
  localparam int unsigned MAXLR = (L > R) ? L : R;
  localparam int unsigned MAXC  = (MAXLR > D) ? MAXLR : D;
  localparam int unsigned CTRBITS = $clog2(MAXC) + 1;

  localparam logic [CTRBITS-1:0] L_M1 = CTRBITS'(L - 1);
  localparam logic [CTRBITS-1:0] R_M1 = CTRBITS'(R - 1);
  localparam logic [CTRBITS-1:0] D_M1 = CTRBITS'(D - 1);

  if (L < 1 || R < 1 || D < 1) begin : g_bad_timing
    $error("button_event: every timing count must be at least one cycle");
  end

  logic w_rise;
  logic w_fall;
  logic w_pb_q_unused;

  pb_edge_det u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (pb_debounced),
    .rise (w_rise),
    .fall (w_fall),
    .q    (w_pb_q_unused)
  );

  state_t             r_state;
  state_t             w_next;
  logic [CTRBITS-1:0] r_timer;

  logic w_press;
  logic w_rel;
  logic w_click;
  logic w_dclick;
  logic w_long;
  logic w_rep;

  logic r_press;
  logic r_rel;
  logic r_click;
  logic r_dclick;
  logic r_long;
  logic r_rep;
  logic r_held;

  // Edges are tested before timeouts so an edge always wins a tie
  always_comb begin
    w_next   = r_state;
    w_press  = 1'b0;
    w_rel    = 1'b0;
    w_click  = 1'b0;
    w_dclick = 1'b0;
    w_long   = 1'b0;
    w_rep    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_next  = DOWN1;
          w_press = 1'b1;
        end
      end
      DOWN1: begin
        if (w_fall) begin
          w_next = WAIT2;
          w_rel  = 1'b1;
        end else if (r_timer == L_M1) begin
          w_next = LONG;
          w_long = 1'b1;
        end
      end
      LONG: begin
        if (w_fall) begin
          w_next = IDLE;
          w_rel  = 1'b1;
        end else if (r_timer == R_M1) begin
          w_rep = 1'b1;
        end
      end
      WAIT2: begin
        if (w_rise) begin
          w_next   = DOWN2;
          w_press  = 1'b1;
          w_dclick = 1'b1;
        end else if (r_timer == D_M1) begin
          w_next  = IDLE;
          w_click = 1'b1;
        end
      end
      DOWN2: begin
        if (w_fall) begin
          w_next = IDLE;
          w_rel  = 1'b1;
        end else if (r_timer == L_M1) begin
          w_next = LONG;
          w_long = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_press  <= 1'b0;
      r_rel    <= 1'b0;
      r_click  <= 1'b0;
      r_dclick <= 1'b0;
      r_long   <= 1'b0;
      r_rep    <= 1'b0;
      r_held   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state || w_rep) begin
        r_timer <= '0;
      end else if (r_timer != '1) begin
        r_timer <= r_timer + 1'b1;
      end
      r_press  <= w_press;
      r_rel    <= w_rel;
      r_click  <= w_click;
      r_dclick <= w_dclick;
      r_long   <= w_long;
      r_rep    <= w_rep;
      r_held   <= (w_next == DOWN1) || (w_next == DOWN2) ||
                  (w_next == LONG);
    end
  end

  assign press      = r_press;
  assign release_p  = r_rel;
  assign click      = r_click;
  assign dclick     = r_dclick;
  assign long_press = r_long;
  assign repeat_p   = r_rep;
  assign held       = r_held;

endmodule

// File: tb/tb_button_event.sv
// Randomized and directed bench for button_event against a
// timestamp-based model of the button gesture rules.
module tb_button_event;

  localparam int L = 8;
  localparam int R = 4;
  localparam int D = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pb = 1'b0;
  logic press, rel, click, dclick, long_press, repeat_p, held;

  always #5 clk = ~clk;

  button_event #(
    .CLKPD_NS (10),
    .CLKFREQ  (1000),
    .LONG_MS  (8),
    .REPEAT_MS(4),
    .DCLICK_MS(5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pb_debounced(pb),
    .press       (press),
    .release_p   (rel),
    .click       (click),
    .dclick      (dclick),
    .long_press  (long_press),
    .repeat_p    (repeat_p),
    .held        (held)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // bit order: press release click dclick long repeat held
  function automatic logic [6:0] outs();
    return {press, rel, click, dclick, long_press, repeat_p, held};
  endfunction

  bit m_down, m_wait, m_long, m_second, m_prev;
  int m_start, m_anchor, m_relt, cyc;
  logic [6:0] m_exp;
  int cnt[7];
  int last[7];

  task automatic model_reset();
    m_down = 0; m_wait = 0; m_long = 0; m_second = 0; m_prev = 0;
    m_exp = '0;
  endtask

  task automatic model_step(input bit p);
    bit rise, fall;
    rise = p & ~m_prev;
    fall = ~p & m_prev;
    m_prev = p;
    m_exp = '0;
    cyc++;
    if (m_down) begin
      if (fall) begin
        m_exp[5] = 1;
        m_down = 0;
        if (!m_long && !m_second) begin
          m_wait = 1;
          m_relt = cyc;
        end
      end else if (!m_long && cyc - m_start == L) begin
        m_exp[2] = 1;
        m_long = 1;
        m_anchor = cyc;
      end else if (m_long && cyc - m_anchor == R) begin
        m_exp[1] = 1;
        m_anchor = cyc;
      end
    end else if (m_wait && rise) begin
      m_exp[6] = 1; m_exp[3] = 1;
      m_wait = 0; m_down = 1; m_second = 1; m_long = 0;
      m_start = cyc;
    end else if (m_wait && cyc - m_relt == D) begin
      m_exp[4] = 1;
      m_wait = 0;
    end else if (!m_wait && rise) begin
      m_exp[6] = 1;
      m_down = 1; m_second = 0; m_long = 0;
      m_start = cyc;
    end
    m_exp[0] = m_down;
  endtask

  task automatic clr();
    for (int i = 0; i < 7; i++) begin
      cnt[i] = 0;
      last[i] = -1;
    end
  endtask

  task automatic step(input bit p);
    logic [6:0] o;
    pb = p;
    @(posedge clk);
    model_step(p);
    #1;
    o = outs();
    chk($sformatf("outs@%0d", cyc), 32'(o), 32'(m_exp));
    if (o[6] & o[5]) chk("press_rel_excl", 32'(o[6] & o[5]), 32'd0);
    for (int i = 0; i < 7; i++) begin
      if (o[i]) begin
        cnt[i]++;
        last[i] = cyc;
      end
    end
  endtask

  task automatic run(input bit p, input int n);
    for (int i = 0; i < n; i++) step(p);
  endtask

  initial begin
    cyc = 0;
    model_reset();
    clr();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 32'(outs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 3);

    // short click
    clr();
    run(1, 3); run(0, 8);
    chk("t1_press", cnt[6], 1);
    chk("t1_release", cnt[5], 1);
    chk("t1_click", cnt[4], 1);
    chk("t1_click_gap", last[4] - last[5], D);
    chk("t1_held_cycles", cnt[0], 3);

    // double click
    clr();
    run(1, 2); run(0, 2); run(1, 2); run(0, 8);
    chk("t2_dclick", cnt[3], 1);
    chk("t2_dclick_eq_press", last[3], last[6]);
    chk("t2_no_click", cnt[4], 0);
    chk("t2_release", cnt[5], 2);

    // long hold with repeats
    clr();
    run(1, 21); run(0, 8);
    chk("t3_long", cnt[2], 1);
    chk("t3_long_gap", last[2] - last[6], L);
    chk("t3_repeats", cnt[1], 3);
    chk("t3_last_rep", last[1] - last[6], 20);
    chk("t3_no_click", cnt[4], 0);
    chk("t3_release", cnt[5], 1);

    // release exactly at long timeout
    clr();
    run(1, 8); run(0, 8);
    chk("t4_no_long", cnt[2], 0);
    chk("t4_release", cnt[5], 1);
    chk("t4_rel_gap", last[5] - last[6], L);
    chk("t4_click_wait2", cnt[4], 1);

    // second press exactly at double-click expiry
    clr();
    run(1, 2); run(0, 5); run(1, 2); run(0, 8);
    chk("t5_dclick", cnt[3], 1);
    chk("t5_no_click", cnt[4], 0);
    chk("t5_dclick_eq_press", last[3], last[6]);

    // random gestures
    for (int b = 0; b < 60; b++) begin
      int len;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(9, 25)
                                        : $urandom_range(1, 7);
      run(b[0] ? 1'b0 : 1'b1, len);
    end
    run(0, 15);

    // async reset mid-hold, button kept down
    clr();
    run(1, 5);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_outs", 32'(outs()), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("t6_held_in_reset", 32'(outs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clr();
    step(1);
    chk("t6_press_first_edge", 32'(press), 32'd1);
    run(1, 2); run(0, 8);
    chk("t6_press_count", cnt[6], 1);
    chk("t6_click", cnt[4], 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
